// File: rtl/bram_uart_streamer.sv
// bram_uart_streamer: streams BRAM words 0..count-1 out to a UART transmitter, MSB byte first.
module bram_uart_streamer #(
    parameter int WORD_WIDTH   = 32,
    parameter int DEPTH        = 25251,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH:0]   count_in,
    input  logic                  abort_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  tx_busy_in,
    output logic [7:0]            byte_out,
    output logic                  byte_valid_out,
    output logic                  busy_out,
    output logic                  done_out
);
    localparam int BYTES = WORD_WIDTH / 8;
    localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    typedef enum logic [2:0] {IDLE, FETCH, SEND, GUARD, WAIT_TX} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d, cnt_sat;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [BW-1:0] bidx_q, bidx_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic valid_q, valid_d, done_q, done_d;
    assign cnt_sat = (count_in > DEPTH_C) ? DEPTH_C : count_in;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start_in) begin
                cnt_d  = cnt_sat;
                addr_d = '0;
                bidx_d = '0;
                lat_d  = LW'(READ_LATENCY);
                if (cnt_sat == '0) done_d = 1'b1;
                else state_d = FETCH;
            end
            FETCH: begin
                lat_d = lat_q - 1'b1;
                if (lat_q <= LW'(1)) begin
                    shift_d = data_in;
                    bidx_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: if (!tx_busy_in) begin
                byte_d  = shift_q[WORD_WIDTH-1 -: 8];
                valid_d = 1'b1;
                shift_d = shift_q << 8;
                state_d = GUARD;
            end
            // transmitter raises busy one cycle after the trigger, so skip one look
            GUARD: state_d = WAIT_TX;
            WAIT_TX: if (!tx_busy_in) begin
                if (bidx_q < BW'(BYTES - 1)) begin
                    bidx_d  = bidx_q + 1'b1;
                    state_d = SEND;
                end else if ({1'b0, addr_q} + (ADDR_WIDTH + 1)'(1) < cnt_q) begin
                    addr_d  = addr_q + 1'b1;
                    lat_d   = LW'(READ_LATENCY);
                    state_d = FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_in && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lat_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end
    assign addr_out       = addr_q;
    assign byte_out       = byte_q;
    assign byte_valid_out = valid_q;
    assign done_out       = done_q;
    assign busy_out       = (state_q != IDLE);
endmodule

// File: tb/tb_bram_uart_streamer.sv
// tb_bram_uart_streamer: directed checks with a BRAM model and a busy-for-10-cycles UART model.
module tb_bram_uart_streamer;
    localparam int DEPTH = 5;
    localparam int AW = $clog2(DEPTH);
    logic clk_in = 1'b0, rst_in = 1'b1, start_in = 1'b0, abort_in = 1'b0, hold = 1'b0;
    logic [AW:0] count_in = '0;
    logic [AW-1:0] addr_out;
    logic [31:0] data_in = '0;
    logic tx_busy_in, byte_valid_out, busy_out, done_out;
    logic [7:0] byte_out;
    logic [31:0] mem [DEPTH];
    int bcnt = 0, cyc = 0, done_cnt = 0, max_addr = 0, scyc = 0, rcyc = 0, base = 0, dbase = 0;
    int total = 0, bad = 0;
    logic [7:0] blog[$];
    int alog[$], tlog[$];

    bram_uart_streamer #(.WORD_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .count_in(count_in),
        .abort_in(abort_in), .addr_out(addr_out), .data_in(data_in), .tx_busy_in(tx_busy_in),
        .byte_out(byte_out), .byte_valid_out(byte_valid_out), .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        data_in <= mem[addr_out];
        if (byte_valid_out) bcnt <= 10;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign tx_busy_in = hold || (bcnt > 0);
    always @(negedge clk_in) begin
        if (byte_valid_out) begin
            blog.push_back(byte_out);
            alog.push_back(int'(addr_out));
            tlog.push_back(cyc);
        end
        if (done_out) done_cnt++;
        if (!rst_in && int'(addr_out) > max_addr) max_addr = int'(addr_out);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(negedge clk_in);
        #1;
    endtask
    task automatic start(input int cnt);
        step();
        start_in = 1'b1;
        count_in = (AW + 1)'(cnt);
        scyc = cyc;
        step();
        start_in = 1'b0;
    endtask
    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        do begin step(); n++; end while (busy_out && n < lim);
        chk(tag, 32'(n < lim), 32'd1);
    endtask
    task automatic wait_log(input string tag, input int sz, input int lim);
        int n = 0;
        while (blog.size() < sz && n < lim) begin step(); n++; end
        chk(tag, 32'(n < lim), 32'd1);
    endtask

    initial begin
        mem[0] = 32'hDEADBEEF; mem[1] = 32'h0; mem[2] = 32'h0; mem[3] = 32'h0; mem[4] = 32'h0;
        repeat (3) step();
        rst_in = 1'b0;
        chk("rst_addr", 32'(addr_out), 0);
        chk("rst_byte", 32'(byte_out), 0);
        chk("rst_valid", 32'(byte_valid_out), 0);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_done", 32'(done_out), 0);
        // single word: trigger is seen 4 edges after the start edge (data at edge 2, SEND at edge 3)
        start(1);
        wait_idle("single_to", 200);
        chk("single_n", blog.size(), 4);
        chk("single_b0", 32'(blog[0]), 32'hDE);
        chk("single_b1", 32'(blog[1]), 32'hAD);
        chk("single_b2", 32'(blog[2]), 32'hBE);
        chk("single_b3", 32'(blog[3]), 32'hEF);
        chk("single_lat", tlog[0] - scyc, 4);
        chk("single_done", done_cnt, 1);
        chk("single_busy", 32'(busy_out), 0);
        // multi-word
        mem[0] = 32'h01020304; mem[1] = 32'h05060708; mem[2] = 32'h090A0B0C;
        base = blog.size();
        start(3);
        wait_idle("multi_to", 500);
        chk("multi_n", blog.size() - base, 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("multi_b%0d", i), 32'(blog[base+i]), i + 1);
            chk($sformatf("multi_a%0d", i), alog[base+i], i / 4);
        end
        chk("multi_lat", tlog[base] - scyc, 4);
        chk("multi_done", done_cnt, 2);
        // zero count
        base = blog.size();
        start(0);
        chk("zero_done_hi", 32'(done_out), 1);
        chk("zero_busy", 32'(busy_out), 0);
        step();
        chk("zero_done_lo", 32'(done_out), 0);
        chk("zero_n", blog.size() - base, 0);
        // saturation: count 10 clips to 5 words
        mem[3] = 32'h11223344; mem[4] = 32'h55667788;
        base = blog.size();
        max_addr = 0;
        start(DEPTH + 5);
        wait_idle("sat_to", 2000);
        chk("sat_n", blog.size() - base, 20);
        chk("sat_maxaddr", max_addr, DEPTH - 1);
        chk("sat_b16", 32'(blog[base+16]), 32'h55);
        chk("sat_b19", 32'(blog[base+19]), 32'h88);
        chk("sat_b12", 32'(blog[base+12]), 32'h11);
        // back-pressure
        base = blog.size();
        hold = 1'b1;
        start(1);
        repeat (50) step();
        chk("bp_none", blog.size() - base, 0);
        chk("bp_busy", 32'(busy_out), 1);
        hold = 1'b0;
        rcyc = cyc;
        wait_log("bp_first_to", base + 1, 20);
        chk("bp_lat", tlog[base] - rcyc, 1);
        wait_idle("bp_to", 200);
        chk("bp_n", blog.size() - base, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp_b%0d", i), 32'(blog[base+i]), i + 1);
        // abort after 2nd byte of word 1, with an ignored start in between
        base = blog.size();
        dbase = done_cnt;
        start(3);
        wait_log("ab_w1_to", base + 1, 50);
        start_in = 1'b1; count_in = 1;
        step();
        start_in = 1'b0;
        wait_log("ab_w6_to", base + 6, 300);
        abort_in = 1'b1;
        step();
        abort_in = 1'b0;
        chk("ab_busy", 32'(busy_out), 0);
        chk("ab_valid", 32'(byte_valid_out), 0);
        repeat (40) step();
        chk("ab_n", blog.size() - base, 6);
        chk("ab_b4", 32'(blog[base+4]), 32'h05);
        chk("ab_b5", 32'(blog[base+5]), 32'h06);
        chk("ab_done", done_cnt - dbase, 0);
        base = blog.size();
        start(1);
        wait_idle("rs_to", 200);
        chk("rs_n", blog.size() - base, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rs_b%0d", i), 32'(blog[base+i]), i + 1);
        chk("rs_done", done_cnt - dbase, 1);
        // reset during WAIT_TX
        base = blog.size();
        dbase = done_cnt;
        start(1);
        wait_log("rm_to", base + 1, 50);
        repeat (3) step();
        rst_in = 1'b1;
        step();
        chk("rm_addr", 32'(addr_out), 0);
        chk("rm_byte", 32'(byte_out), 0);
        chk("rm_valid", 32'(byte_valid_out), 0);
        chk("rm_busy", 32'(busy_out), 0);
        chk("rm_done", 32'(done_out), 0);
        rst_in = 1'b0;
        repeat (40) step();
        chk("rm_n", blog.size() - base, 1);
        chk("rm_nodone", done_cnt - dbase, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
